// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      MULT  = 2'b00,
      MULTU = 2'b01,
      DIV   = 2'b10,
      DIVU  = 2'b11
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } muldiv_state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider working on operand magnitudes, with sign fix-up.
// MULDIV_EARLY_OUT_EN: flag multiplies whose remaining multiplier bits are all zero.
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            early_out,
   output logic [XLEN-1:0] res_hi,
   output logic [XLEN-1:0] res_lo
);

   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] sh;
   logic [XLEN-1:0]   mq;
   logic              div_r;
   logic              sign_a;
   logic              neg_res;
   logic              div_zero;

   logic              sa;
   logic              sb;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     diff;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;

   always_comb begin
      sa     = op_is_signed(op) & op_a[XLEN-1];
      sb     = op_is_signed(op) & op_b[XLEN-1];
      mag_a  = sa ? -op_a : op_a;
      mag_b  = sb ? -op_b : op_b;
      rem_sh = {acc[XLEN-1:0], mq[XLEN-1]};
      diff   = rem_sh - {1'b0, sh[XLEN-1:0]};
   end

   // mult: acc = product, sh = shifted multiplicand, mq = multiplier consumed LSB-first
   // div:  acc = partial remainder, sh = divisor, mq = dividend turning into quotient
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         sh       <= '0;
         mq       <= '0;
         div_r    <= 1'b0;
         sign_a   <= 1'b0;
         neg_res  <= 1'b0;
         div_zero <= 1'b0;
      end else if (load) begin
         div_r    <= op_is_div(op);
         sign_a   <= sa;
         neg_res  <= sa ^ sb;
         div_zero <= (op_b == '0);
         acc      <= '0;
         mq       <= op_is_div(op) ? mag_a : mag_b;
         sh       <= {{XLEN{1'b0}}, (op_is_div(op) ? mag_b : mag_a)};
      end else if (step) begin
         if (div_r) begin
            if (!diff[XLEN]) begin
               acc <= {{(XLEN-1){1'b0}}, diff};
               mq  <= {mq[XLEN-2:0], 1'b1};
            end else begin
               acc <= {{(XLEN-1){1'b0}}, rem_sh};
               mq  <= {mq[XLEN-2:0], 1'b0};
            end
         end else begin
            if (mq[0]) acc <= acc + sh;
            sh <= sh << 1;
            mq <= mq >> 1;
         end
      end
   end

   always_comb begin
      prod = neg_res ? -acc : acc;
      quo  = neg_res ? -mq : mq;
      rem  = sign_a ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      if (div_r) begin
         // remainder of x/0 is |x| re-signed, i.e. the original dividend
         res_hi = rem;
         res_lo = div_zero ? '1 : quo;
      end else begin
         res_hi = prod[2*XLEN-1:XLEN];
         res_lo = prod[XLEN-1:0];
      end
   end

`ifdef MULDIV_EARLY_OUT_EN
   assign early_out = ~div_r & (mq[XLEN-1:1] == '0);
`else
   assign early_out = 1'b0;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for MIPS MULT/MULTU/DIV/DIVU owning HI/LO and the EX stall request.
// MULDIV_EARLY_OUT_EN: multiplies may leave CALC before XLEN iterations.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write hi/lo here
// CALC  | one shift-add / restoring-divide iteration per cycle
// FIX   | sign-corrected result written to hi/lo, done pulsed
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            rd_hilo,
   input  logic            wr_hi,
   input  logic            wr_lo,
   input  logic [XLEN-1:0] wr_data,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            busy,
   output logic            done,
   output logic            stall
);

   localparam int CW = $clog2(XLEN);

   muldiv_state_e   state;
   logic [CW-1:0]   count;
   logic            load;
   logic            step;
   logic            early_out;
   logic            last_iter;
   logic [XLEN-1:0] res_hi;
   logic [XLEN-1:0] res_lo;

   assign busy      = (state != IDLE);
   assign stall     = busy & (start | rd_hilo | wr_hi | wr_lo);
   assign load      = (state == IDLE) & start;
   assign step      = (state == CALC);
   assign last_iter = (count == '0) | early_out;

   muldiv_datapath #(.XLEN(XLEN)) u_datapath (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .step      (step),
      .op        (op),
      .op_a      (op_a),
      .op_b      (op_b),
      .early_out (early_out),
      .res_hi    (res_hi),
      .res_lo    (res_lo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= CALC;
                  count <= CW'(XLEN-1);
               end else begin
                  if (wr_hi) hi <= wr_data;
                  if (wr_lo) lo <= wr_data;
               end
            end
            CALC: begin
               if (last_iter) state <= FIX;
               else           count <= count - CW'(1);
            end
            FIX: begin
               hi    <= res_hi;
               lo    <= res_lo;
               done  <= 1'b1;
               count <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; expected results are hand-computed constants.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int XLEN = XLEN_DEFAULT;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            rd_hilo;
   logic            wr_hi;
   logic            wr_lo;
   logic [XLEN-1:0] wr_data;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic            busy;
   logic            done;
   logic            stall;

   int n_checks = 0;
   int n_pass   = 0;

   muldiv_ctrl #(.XLEN(XLEN)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .op_a    (op_a),
      .op_b    (op_b),
      .rd_hilo (rd_hilo),
      .wr_hi   (wr_hi),
      .wr_lo   (wr_lo),
      .wr_data (wr_data),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy),
      .done    (done),
      .stall   (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // lat = number of rising edges after the start edge until done is seen high
   task automatic do_op(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        output int lat);
      @(negedge clk);
      start = 1'b1; op = o; op_a = a; op_b = b;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("done_seen", 64'(done), 64'd1);
   endtask

   int  lat;
   int  nbusy;
   int  bad;
   int  cyc;
   logic seen_done;

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
      rd_hilo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
      repeat (3) @(negedge clk);
      check("rst_hi",    64'(hi),    64'd0);
      check("rst_lo",    64'(lo),    64'd0);
      check("rst_busy",  64'(busy),  64'd0);
      check("rst_done",  64'(done),  64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      rst_n = 1'b1;

      // 7 * -3 = -21; done rises on edge E+XLEN+1, i.e. the (XLEN+2)th cycle counting the start cycle
      do_op(MULT, 32'd7, 32'hFFFF_FFFD, lat);
`ifdef MULDIV_EARLY_OUT_EN
      check("mult_latency_early", 64'(lat), 64'd3);
`else
      check("mult_latency", 64'(lat), 64'(XLEN + 1));
`endif
      check("mult_hi",   64'(hi),   64'hFFFF_FFFF);
      check("mult_lo",   64'(lo),   64'hFFFF_FFEB);
      check("mult_busy", 64'(busy), 64'd0);

      do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
      check("multu_lo", 64'(lo), 64'h0000_0001);

      do_op(DIV, 32'hFFFF_FFF9, 32'd2, lat);
      check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
      check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
      check("div_latency", 64'(lat), 64'(XLEN + 1));

      do_op(DIVU, 32'd7, 32'd2, lat);
      check("divu_lo", 64'(lo), 64'd3);
      check("divu_hi", 64'(hi), 64'd1);

      do_op(DIV, 32'd5, 32'd0, lat);
      check("div0_hi",      64'(hi),  64'd5);
      check("div0_lo",      64'(lo),  64'hFFFF_FFFF);
      check("div0_latency", 64'(lat), 64'(XLEN + 1));

      do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      check("div_ovf_lo", 64'(lo), 64'h8000_0000);
      check("div_ovf_hi", 64'(hi), 64'd0);

      // mixed signs: -100 * 5 = -500, -100 / 7 = -14 rem -2
      do_op(MULT, 32'hFFFF_FF9C, 32'd5, lat);
      check("mult_mix_hi", 64'(hi), 64'hFFFF_FFFF);
      check("mult_mix_lo", 64'(lo), 64'hFFFF_FE0C);
      do_op(DIV, 32'hFFFF_FF9C, 32'd7, lat);
      check("div_mix_lo", 64'(lo), 64'hFFFF_FFF2);
      check("div_mix_hi", 64'(hi), 64'hFFFF_FFFE);

      // rd_hilo held through a whole DIVU 100/7
      @(negedge clk);
      start = 1'b1; op = DIVU; op_a = 32'd100; op_b = 32'd7; rd_hilo = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nbusy = 0; bad = 0; cyc = 0;
      while (!done && cyc < 200) begin
         if (busy) nbusy++;
         if (busy && !stall) bad++;
         @(negedge clk);
         cyc++;
      end
      check("stall_done_seen", 64'(done),  64'd1);
      check("stall_busy_cnt",  64'(nbusy), 64'(XLEN + 1));
      check("stall_missing",   64'(bad),   64'd0);
      check("stall_done_cyc",  64'(stall), 64'd0);
      check("divu100_lo",      64'(lo),    64'd14);
      check("divu100_hi",      64'(hi),    64'd2);
      rd_hilo = 1'b0;

      // MTHI / MTLO in IDLE
      @(negedge clk);
      wr_hi = 1'b1; wr_data = 32'h0000_ABCD;
      @(negedge clk);
      wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h0000_5555;
      @(negedge clk);
      wr_lo = 1'b0;
      check("mthi", 64'(hi), 64'h0000_ABCD);
      check("mtlo", 64'(lo), 64'h0000_5555);

      // MTLO together with start: start wins, the write is dropped
      start = 1'b1; op = MULTU; op_a = 32'd2; op_b = 32'd3; wr_lo = 1'b1; wr_data = 32'h0000_1234;
      @(negedge clk);
      start = 1'b0; wr_lo = 1'b0;
      check("mtlo_dropped", 64'(lo),   64'h0000_5555);
      check("start_taken",  64'(busy), 64'd1);
      // MTHI while busy is ignored
      wr_hi = 1'b1; wr_data = 32'h0000_9999;
      @(negedge clk);
      check("busy_stall_wr", 64'(stall), 64'd1);
      wr_hi = 1'b0;
      check("mthi_ignored", 64'(hi), 64'h0000_ABCD);
      cyc = 0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("multu_small_lo", 64'(lo), 64'd6);
      check("multu_small_hi", 64'(hi), 64'd0);

      // reset in the middle of CALC
      @(negedge clk);
      start = 1'b1; op = MULT; op_a = 32'd7; op_b = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_hi",   64'(hi),   64'd0);
      check("midrst_lo",   64'(lo),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("midrst_no_done", 64'(seen_done), 64'd0);
      check("midrst_lo_held", 64'(lo),        64'd0);

      do_op(MULT, 32'd3, 32'd1, lat);
`ifdef MULDIV_EARLY_OUT_EN
      check("early_latency", 64'(lat), 64'd2);
`else
      check("fixed_latency", 64'(lat), 64'(XLEN + 1));
`endif
      check("mult31_lo", 64'(lo), 64'd3);
      check("mult31_hi", 64'(hi), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
